rs232_tx_arbiter: RTL

Round-robin arbiter that shares the single rs232 transmitter among several on-chip requesters. It sits between the requester blocks and the `tx_data`/`tx_start`/`tx_ready` port of the rs232 core and sequences one byte at a time through that core. A lock facility gives one requester uninterrupted access for a multi-byte message. A watchdog recovers the arbiter when the core fails to accept a byte.

---
 rtl/rs232_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one rs232 transmitter among N_REQ requesters,
// with an owner lock for multi-byte messages and an accept watchdog.
module rs232_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ACCEPT_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            lock,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        tx_err,
    input  logic                        tx_ready,
    output logic [DATA_WIDTH-1:0]       tx_data,
    output logic                        tx_start
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(ACCEPT_TIMEOUT);
    localparam int LK_W  = $clog2(LOCK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACCEPT_TIMEOUT - 1);
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state, state_n;
    logic [PTR_W-1:0]      rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]      winner, winner_n;
    logic [WD_W-1:0]       wd_cnt, wd_cnt_n;
    logic [LK_W-1:0]       lk_cnt, lk_cnt_n;
    logic                  locked, locked_n;
    logic [N_REQ-1:0]      ack_n, grant_n;
    logic                  tx_err_n, tx_start_n;
    logic [DATA_WIDTH-1:0] tx_data_n;

    logic [DATA_WIDTH-1:0] req_byte [N_REQ];
    logic [PTR_W-1:0]      rr_idx, rr_pick;
    logic                  rr_found;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_byte[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    // First requester at or above rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        winner_n   = winner;
        wd_cnt_n   = wd_cnt;
        lk_cnt_n   = lk_cnt;
        locked_n   = locked;
        grant_n    = grant;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        ack_n      = '0;
        tx_err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (locked) begin
                    if (!lock[winner] || lk_cnt == LK_LAST) begin
                        locked_n = 1'b0;
                        lk_cnt_n = '0;
                        grant_n  = '0;
                        rr_ptr_n = ptr_inc(winner);
                    end else if (req[winner] && tx_ready) begin
                        tx_data_n  = req_byte[winner];
                        tx_start_n = 1'b1;
                        lk_cnt_n   = '0;
                        state_n    = START;
                    end else if (!req[winner]) begin
                        lk_cnt_n = lk_cnt + 1'b1;
                    end
                end else if (rr_found && tx_ready) begin
                    winner_n   = rr_pick;
                    grant_n    = N_REQ'(1) << rr_pick;
                    tx_data_n  = req_byte[rr_pick];
                    tx_start_n = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                wd_cnt_n = '0;
                state_n  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    ack_n   = N_REQ'(1) << winner;
                    state_n = WAIT_DONE;
                end else if (wd_cnt == WD_LAST) begin
                    // Core never took the byte: drop the owner and any lock it held.
                    tx_err_n = 1'b1;
                    rr_ptr_n = ptr_inc(winner);
                    grant_n  = '0;
                    locked_n = 1'b0;
                    lk_cnt_n = '0;
                    state_n  = IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_n  = IDLE;
                    lk_cnt_n = '0;
                    if (lock[winner]) begin
                        locked_n = 1'b1;
                    end else begin
                        locked_n = 1'b0;
                        grant_n  = '0;
                        rr_ptr_n = ptr_inc(winner);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner   <= '0;
            wd_cnt   <= '0;
            lk_cnt   <= '0;
            locked   <= 1'b0;
            grant    <= '0;
            ack      <= '0;
            tx_err   <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            winner   <= winner_n;
            wd_cnt   <= wd_cnt_n;
            lk_cnt   <= lk_cnt_n;
            locked   <= locked_n;
            grant    <= grant_n;
            ack      <= ack_n;
            tx_err   <= tx_err_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
